// File: rtl/minimac_txser.sv
// MAC transmit serialiser: pops frame bytes from an FWFT FIFO and drives the
// MII nibble bus with preamble/SFD, optional FCS, IFG and underrun abort.
`timescale 1ns/1ps

module minimac_txser #(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES      = 24,
    parameter bit APPEND_FCS       = 1'b1
) (
    input  logic       phy_tx_clk,
    input  logic       phy_tx_rst_n,
    input  logic       tx_enable,
    input  logic [8:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic [3:0] phy_tx_data,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_LO,
        S_HI,
        S_FCS,
        S_DRAIN,
        S_IFG
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_NIBBLES);
    localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_crc;
    logic [3:0]  r_txd;
    logic        r_en;
    logic        r_er;
    logic        r_done;
    logic        r_und;

    logic        w_start;
    logic        w_last;
    logic [3:0]  w_lo;
    logic [3:0]  w_hi;

    // Reflected CRC-32, one nibble per call, bit 0 of the nibble first.
    function automatic logic [31:0] f_crc4(input logic [31:0] crc,
                                           input logic [3:0]  d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ d[i])
                c = (c >> 1) ^ 32'hEDB8_8320;
            else
                c = c >> 1;
        end
        return c;
    endfunction

    assign w_start = tx_enable && !fifo_empty;
    assign w_last  = fifo_data[8];
    assign w_lo    = fifo_data[3:0];
    assign w_hi    = fifo_data[7:4];

    // Pop only on the high nibble, or while discarding an aborted frame.
    assign fifo_rd = !fifo_empty
                  && ((r_state == S_HI) || (r_state == S_DRAIN));

    assign phy_tx_data = r_txd;
    assign phy_tx_en   = r_en;
    assign phy_tx_er   = r_er;
    assign tx_done     = r_done;
    assign tx_underrun = r_und;
    assign tx_busy     = (r_state != S_IDLE);

    always_ff @(posedge phy_tx_clk or negedge phy_tx_rst_n) begin
        if (!phy_tx_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_crc   <= 32'hFFFF_FFFF;
            r_txd   <= '0;
            r_en    <= 1'b0;
            r_er    <= 1'b0;
            r_done  <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_txd  <= '0;
            r_en   <= 1'b0;
            r_er   <= 1'b0;
            r_done <= 1'b0;
            r_und  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_crc <= 32'hFFFF_FFFF;
                    if (w_start) begin
                        r_en    <= 1'b1;
                        r_txd   <= 4'h5;
                        r_cnt   <= 16'd1;
                        r_state <= S_PRE;
                    end
                end
                S_PRE: begin
                    r_en <= 1'b1;
                    if (r_cnt == PRE_LAST) begin
                        r_txd   <= 4'hD;
                        r_state <= S_LO;
                    end else begin
                        r_txd <= 4'h5;
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_LO: begin
                    r_en <= 1'b1;
                    if (fifo_empty) begin
                        r_er    <= 1'b1;
                        r_und   <= 1'b1;
                        r_state <= S_DRAIN;
                    end else begin
                        r_txd   <= w_lo;
                        r_crc   <= f_crc4(r_crc, w_lo);
                        r_state <= S_HI;
                    end
                end
                S_HI: begin
                    r_en  <= 1'b1;
                    r_txd <= w_hi;
                    r_crc <= f_crc4(r_crc, w_hi);
                    r_cnt <= '0;
                    if (!w_last) begin
                        r_state <= S_LO;
                    end else if (APPEND_FCS) begin
                        r_state <= S_FCS;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_IFG;
                    end
                end
                S_FCS: begin
                    r_en  <= 1'b1;
                    r_txd <= ~r_crc[3:0];
                    r_crc <= r_crc >> 4;
                    if (r_cnt == 16'd7) begin
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IFG;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= '0;
                    if (!fifo_empty && w_last)
                        r_state <= S_IFG;
                end
                S_IFG: begin
                    if (r_cnt == IFG_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
